// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board-input conditioner: reset levels of the
// debounced outputs and the default debounce timing for a 50 MHz clock.
package input_conditioner_pkg;

  // Pushbuttons are active-low, so "released" is all ones.
  localparam logic [1:0] KEY_RELEASED = 2'b11;

  // Slide switches come out of reset reading zero.
  localparam logic [7:0] SW_RESET = 8'h00;

  // 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Smallest width with 2**CNT_W > DEFAULT_DEBOUNCE_CYCLES.
  localparam int DEFAULT_CNT_W = 19;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_bit.sv
// One conditioned input: two-flop synchroniser, debounce counter, accepted
// (stable) level, and registered one-cycle rise/fall pulses that line up
// with the first cycle of the new stable level.
module debounce_bit #(
  parameter logic RESET_VAL       = 1'b0,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  // Terminal count: the cycle on which a persistent disagreement is accepted.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state: synchronise, then count consecutive cycles of disagreement.
  // NOTE: every _d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;

    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        // Disagreement has persisted long enough: accept the new level.
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Agreement (or a glitch ending) leaves cnt_d at zero, aborting the count.

    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  // State register with synchronous active-high reset.
  // NOTE: non-blocking assignments keep every flop sampling the pre-edge
  // values, so the synchroniser really is two stages deep.
  // NOTE: the synchroniser stages are reset to the idle level as well, so a
  // button held during reset cannot leak a phantom transition afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign db   = stable_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule : debounce_bit

// File: rtl/input_conditioner.sv
// DE10-Lite board-input front end: conditions KEY[1:0] and SW[7:0] into
// clean debounced levels plus press/release/change pulses for the lab logic.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RST,
  input  logic [1:0] KEY,
  input  logic [7:0] SW,
  output logic [1:0] KEY_DB,
  output logic [7:0] SW_DB,
  output logic [1:0] KEY_PRESS,
  output logic [1:0] KEY_RELEASE,
  output logic       SW_CHG
);

  logic [7:0] sw_rise;
  logic [7:0] sw_fall;

  // Active-low buttons: a press is a falling debounced level.
  for (genvar i = 0; i < 2; i++) begin : g_key
    debounce_bit #(
      .RESET_VAL      (KEY_RELEASED[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk (MAX10_CLK1_50),
      .rst (RST),
      .raw (KEY[i]),
      .db  (KEY_DB[i]),
      .rise(KEY_RELEASE[i]),
      .fall(KEY_PRESS[i])
    );
  end

  for (genvar i = 0; i < 8; i++) begin : g_sw
    debounce_bit #(
      .RESET_VAL      (SW_RESET[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk (MAX10_CLK1_50),
      .rst (RST),
      .raw (SW[i]),
      .db  (SW_DB[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end

  // Per-bit pulses are already registered; any switch edge flags a change.
  assign SW_CHG = |(sw_rise | sw_fall);

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// The stimulus process drives one cycle at a time and pushes the hand-derived
// expected outputs for that edge; a monitor pops and compares on the
// falling edge.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam int CW = 3;

  typedef struct {
    string      name;
    logic [1:0] kdb;
    logic [7:0] swdb;
    logic [1:0] press;
    logic [1:0] rel;
    logic       chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [7:0] sw;
  logic [1:0] key_db;
  logic [7:0] sw_db;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic       sw_chg;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RST          (rst),
    .KEY          (key),
    .SW           (sw),
    .KEY_DB       (key_db),
    .SW_DB        (sw_db),
    .KEY_PRESS    (key_press),
    .KEY_RELEASE  (key_release),
    .SW_CHG       (sw_chg)
  );

  always #5 clk = ~clk;

  // Drive n identical cycles; each edge's expected outputs go to the scoreboard.
  task automatic run(input string name, input int n, input logic r,
                     input logic [1:0] k, input logic [7:0] s,
                     input logic [1:0] e_kdb, input logic [7:0] e_swdb,
                     input logic [1:0] e_press, input logic [1:0] e_rel,
                     input logic e_chg);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      key = k;
      sw  = s;
      @(posedge clk);
      #1;
      e.name  = name;
      e.kdb   = e_kdb;
      e.swdb  = e_swdb;
      e.press = e_press;
      e.rel   = e_rel;
      e.chg   = e_chg;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({key_db, sw_db, key_press, key_release, sw_chg} !==
          {e.kdb, e.swdb, e.press, e.rel, e.chg}) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got KEY_DB=%b SW_DB=%h PRESS=%b REL=%b CHG=%b, expected KEY_DB=%b SW_DB=%h PRESS=%b REL=%b CHG=%b",
                 e.name, cyc, key_db, sw_db, key_press, key_release, sw_chg,
                 e.kdb, e.swdb, e.press, e.rel, e.chg);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key = 2'b00;
    sw  = 8'hFF;

    // Reset with buttons pressed and switches up: outputs stay at reset values.
    run("reset", 2, 1'b1, 2'b00, 8'hFF, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);

    // Clean switch change: accepted on the 6th edge, one SW_CHG pulse.
    run("clean_wait", 5, 1'b0, 2'b11, 8'hA5, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
    run("clean_acc",  1, 1'b0, 2'b11, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b1);
    run("clean_hold", 4, 1'b0, 2'b11, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);

    // Three-cycle glitch on KEY[0] is one short of acceptance: rejected.
    run("glitch_lo",  3,  1'b0, 2'b10, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);
    run("glitch_hi",  17, 1'b0, 2'b11, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);

    // KEY[1] held for 10 cycles: press pulse at edge 6, release 6 edges after.
    run("press_wait", 5, 1'b0, 2'b01, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);
    run("press_acc",  1, 1'b0, 2'b01, 8'hA5, 2'b01, 8'hA5, 2'b10, 2'b00, 1'b0);
    run("press_hold", 4, 1'b0, 2'b01, 8'hA5, 2'b01, 8'hA5, 2'b00, 2'b00, 1'b0);
    run("rel_wait",   5, 1'b0, 2'b11, 8'hA5, 2'b01, 8'hA5, 2'b00, 2'b00, 1'b0);
    run("rel_acc",    1, 1'b0, 2'b11, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b10, 1'b0);
    run("rel_hold",   3, 1'b0, 2'b11, 8'hA5, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);

    // SW[3] bounces in 2-cycle runs for 12 cycles, then settles high.
    for (int i = 0; i < 12; i++) begin
      run("bounce", 1, 1'b0, 2'b11, (((i / 2) % 2) == 0) ? 8'hAD : 8'hA5,
          2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);
    end
    run("bounce_wait", 5, 1'b0, 2'b11, 8'hAD, 2'b11, 8'hA5, 2'b00, 2'b00, 1'b0);
    run("bounce_acc",  1, 1'b0, 2'b11, 8'hAD, 2'b11, 8'hAD, 2'b00, 2'b00, 1'b1);
    run("bounce_hold", 3, 1'b0, 2'b11, 8'hAD, 2'b11, 8'hAD, 2'b00, 2'b00, 1'b0);

    // Reset on the 3rd edge of a pending change discards it; full latency after.
    run("midrst_cnt", 2, 1'b0, 2'b11, 8'h01, 2'b11, 8'hAD, 2'b00, 2'b00, 1'b0);
    run("midrst_rst", 1, 1'b1, 2'b11, 8'h01, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
    run("midrst_wait", 5, 1'b0, 2'b11, 8'h01, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
    run("midrst_acc",  1, 1'b0, 2'b11, 8'h01, 2'b11, 8'h01, 2'b00, 2'b00, 1'b1);
    run("midrst_hold", 3, 1'b0, 2'b11, 8'h01, 2'b11, 8'h01, 2'b00, 2'b00, 1'b0);

    // Let the monitor drain the last expectation, then confirm nothing is left.
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_conditioner
